button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 182 ++++++++++++++++++
 tb/tb_button_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, registered
// press/release/long-hold pulses, press toggle and 8-bit press counter.
module button_debounce #(
  parameter int p_debounce   = 250000,
  parameter int p_long       = 25000000,
  parameter bit p_active_low = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_toggle,
  output logic [7:0] o_count
);

  localparam int dw = $clog2(p_debounce) + 1;
  localparam int hw = $clog2(p_long) + 1;
  localparam logic [dw-1:0] d_zero = {dw{1'b0}};
  localparam logic [dw-1:0] d_one  = dw'(1);
  localparam logic [dw-1:0] d_last = dw'(p_debounce - 1);
  localparam logic [hw-1:0] h_zero = {hw{1'b0}};
  localparam logic [hw-1:0] h_one  = hw'(1);
  localparam logic [hw-1:0] h_sat  = hw'(p_long);
  localparam logic [hw-1:0] h_pre  = hw'(p_long - 2);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_HELD      = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

  logic          sync1_r, sync2_r;
  state_t        state_r, state_s;
  logic [dw-1:0] d_r, d_s;
  logic [hw-1:0] h_r, h_s, h_inc_s;
  logic          long_done_r, long_done_s;
  logic          level_r, level_s;
  logic          press_r, press_s;
  logic          release_r, release_s;
  logic          long_r, long_s;
  logic          toggle_r, toggle_s;
  logic [7:0]    count_r, count_s;
  logic          pressed_s;
  logic          fire_long_s;

  assign pressed_s = sync2_r ^ p_active_low;

  // State, counter and output registers; synchroniser resets to the idle pad level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_r     <= p_active_low;
      sync2_r     <= p_active_low;
      state_r     <= S_IDLE;
      d_r         <= d_zero;
      h_r         <= h_zero;
      long_done_r <= 1'b0;
      level_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      long_r      <= 1'b0;
      toggle_r    <= 1'b0;
      count_r     <= 8'd0;
    end else begin
      sync1_r     <= i_btn;
      sync2_r     <= sync1_r;
      state_r     <= state_s;
      d_r         <= d_s;
      h_r         <= h_s;
      long_done_r <= long_done_s;
      level_r     <= level_s;
      press_r     <= press_s;
      release_r   <= release_s;
      long_r      <= long_s;
      toggle_r    <= toggle_s;
      count_r     <= count_s;
    end
  end

  // Next-state and next-output logic for the debounce FSM
  always_comb begin
    state_s     = state_r;
    d_s         = d_r;
    h_s         = h_r;
    long_done_s = long_done_r;
    level_s     = level_r;
    toggle_s    = toggle_r;
    count_s     = count_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    long_s      = 1'b0;
    if (h_r < h_sat) begin
      h_inc_s = h_r + h_one;
    end else begin
      h_inc_s = h_r;
    end
    fire_long_s = (h_r == h_pre) && !long_done_r;

    case (state_r)
      S_IDLE: begin
        if (pressed_s) begin
          state_s = S_DEB_PRESS;
          d_s     = d_one;
        end else begin
          d_s = d_zero;
        end
      end
      S_DEB_PRESS: begin
        if (!pressed_s) begin
          state_s = S_IDLE;
          d_s     = d_zero;
        end else if (d_r == d_last) begin
          state_s     = S_HELD;
          d_s         = d_zero;
          h_s         = h_zero;
          long_done_s = 1'b0;
          level_s     = 1'b1;
          press_s     = 1'b1;
          toggle_s    = ~toggle_r;
          count_s     = count_r + 8'd1;
        end else begin
          d_s = d_r + d_one;
        end
      end
      S_HELD: begin
        h_s = h_inc_s;
        if (fire_long_s) begin
          long_s      = 1'b1;
          long_done_s = 1'b1;
        end else begin
          long_done_s = long_done_r;
        end
        if (!pressed_s) begin
          state_s = S_DEB_REL;
          d_s     = d_one;
        end else begin
          d_s = d_zero;
        end
      end
      S_DEB_REL: begin
        h_s = h_inc_s;
        if (fire_long_s) begin
          long_s      = 1'b1;
          long_done_s = 1'b1;
        end else begin
          long_done_s = long_done_r;
        end
        if (pressed_s) begin
          state_s = S_HELD;
          d_s     = d_zero;
        end else if (d_r == d_last) begin
          // A long pulse owns this edge; the release lands one cycle later
          if (fire_long_s) begin
            d_s = d_r;
          end else begin
            state_s   = S_IDLE;
            d_s       = d_zero;
            level_s   = 1'b0;
            release_s = 1'b1;
          end
        end else begin
          d_s = d_r + d_one;
        end
      end
      default: begin
        state_s = S_IDLE;
        d_s     = d_zero;
      end
    endcase
  end

  assign o_level   = level_r;
  assign o_press   = press_r;
  assign o_release = release_r;
  assign o_long    = long_r;
  assign o_toggle  = toggle_r;
  assign o_count   = count_r;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: expected pulse edges are queued as the
// pad is driven and matched against the pulses the DUT produces.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic       o_level, o_press, o_release, o_long, o_toggle;
  logic [7:0] o_count;

  typedef struct {
    int kind;    // 0 press, 1 release, 2 long
    int edge_n;
  } ev_t;

  ev_t exp_q[$];
  int  edge_cnt = 0;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  int  n_press  = 0;
  int  n_rel    = 0;

  button_debounce #(
    .p_debounce  (4),
    .p_long      (20),
    .p_active_low(1'b1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn    (btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_toggle (o_toggle),
    .o_count  (o_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic take(input int kind);
    ev_t e;
    chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_edge", edge_cnt, e.edge_n);
      if (kind == 0) chk("level_after_press", 32'(o_level), 32'd1);
      if (kind == 1) chk("level_after_release", 32'(o_level), 32'd0);
    end
  endtask

  // Pulses are sampled on the falling edge, away from the registering edge
  always @(negedge clk) begin
    if (!rst) begin
      if (o_press)   begin n_press++; take(0); end
      if (o_release) begin n_rel++;   take(1); end
      if (o_long)    take(2);
    end
  end

  task automatic push(input int kind, input int edge_n);
    ev_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_level"},   32'(o_level),   32'd0);
    chk({tag, "_press"},   32'(o_press),   32'd0);
    chk({tag, "_release"}, 32'(o_release), 32'd0);
    chk({tag, "_long"},    32'(o_long),    32'd0);
    chk({tag, "_toggle"},  32'(o_toggle),  32'd0);
    chk({tag, "_count"},   32'(o_count),   32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    outs_zero("reset");
    exp_q.delete();
    hold(cycles);
    rst = 1'b0;
    n_press = 0;
    n_rel   = 0;
  endtask

  initial begin
    int n;
    @(negedge clk);
    do_reset(5);

    // 1: idle with pad released
    btn = 1'b1;
    hold(50);
    outs_zero("idle");

    // 2: clean press of 10 cycles
    do_reset(5);
    btn = 1'b0; n = edge_cnt;
    push(0, n + 6);
    hold(10);
    btn = 1'b1;
    push(1, n + 16);
    hold(10);
    chk("clean_toggle", 32'(o_toggle), 32'd1);
    chk("clean_count", 32'(o_count), 32'd1);
    chk("clean_drained", exp_q.size(), 32'd0);

    // 3: bouncy press
    do_reset(5);
    btn = 1'b0; hold(3);
    btn = 1'b1; hold(1);
    btn = 1'b0; hold(2);
    btn = 1'b1; hold(1);
    btn = 1'b0; n = edge_cnt;
    push(0, n + 6);
    hold(8);
    btn = 1'b1;
    push(1, n + 14);
    hold(10);
    chk("bounce_count", 32'(o_count), 32'd1);
    chk("bounce_presses", n_press, 32'd1);
    chk("bounce_drained", exp_q.size(), 32'd0);

    // 4: long hold with a 2-cycle glitch
    do_reset(5);
    btn = 1'b0; n = edge_cnt;
    push(0, n + 6);
    push(2, n + 25);
    hold(25);
    btn = 1'b1; hold(2);
    btn = 1'b0; hold(13);
    btn = 1'b1;
    push(1, n + 46);
    hold(10);
    chk("long_releases", n_rel, 32'd1);
    chk("long_drained", exp_q.size(), 32'd0);

    // 4b: release acceptance coincides with the long pulse
    do_reset(5);
    btn = 1'b0; n = edge_cnt;
    push(0, n + 6);
    push(2, n + 25);
    hold(19);
    btn = 1'b1;
    push(1, n + 26);
    hold(12);
    chk("coinc_level", 32'(o_level), 32'd0);
    chk("coinc_drained", exp_q.size(), 32'd0);

    // 5: 257 presses wrap the counter
    do_reset(5);
    for (int i = 0; i < 257; i++) begin
      btn = 1'b0; n = edge_cnt;
      push(0, n + 6);
      hold(6);
      btn = 1'b1;
      push(1, n + 12);
      hold(6);
    end
    hold(10);
    chk("wrap_count", 32'(o_count), 32'd1);
    chk("wrap_toggle", 32'(o_toggle), 32'd1);
    chk("wrap_presses", n_press, 32'd257);
    chk("wrap_releases", n_rel, 32'd257);
    chk("wrap_drained", exp_q.size(), 32'd0);

    // 6: reset while held
    do_reset(5);
    btn = 1'b0; n = edge_cnt;
    push(0, n + 6);
    hold(10);
    chk("mid_level_before", 32'(o_level), 32'd1);
    chk("mid_drained_before", exp_q.size(), 32'd0);
    do_reset(1);
    n = edge_cnt;
    push(0, n + 6);
    hold(10);
    btn = 1'b1;
    push(1, n + 16);
    hold(10);
    chk("mid_count", 32'(o_count), 32'd1);
    chk("mid_toggle", 32'(o_toggle), 32'd1);
    chk("mid_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
